cmp_result_stats: RTL and testbench

- Downstream consumer of the 2-bit comparator's three flag outputs (b_gt, b_a_eq, a_gt).
- Over a window of WINDOW valid samples it counts each outcome and counts invalid (not one-hot) flag patterns.
- Publishes the totals with a one-cycle done pulse.
- Used on the board and in benches as a self-checking statistics stage behind the comparator.

---
 rtl/cmp_stats_pkg.sv | 35 +++
 rtl/sat_counter.sv | 22 ++
 rtl/cmp_result_stats.sv | 136 +++++++++++++
 tb/tb_cmp_result_stats.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_stats_pkg.sv
// Shared types for the comparator result statistics block: FSM states,
// one-hot flag patterns and a sample classifier.
package cmp_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] FLAG_B_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ   = 3'b010;
  localparam logic [2:0] FLAG_A_GT = 3'b001;

  typedef struct packed {
    logic b_gt;
    logic eq;
    logic a_gt;
    logic err;
  } sample_class_t;

  // Map a {b_gt, b_a_eq, a_gt} flag vector to exactly one outcome bucket.
  function automatic sample_class_t classify(input logic [2:0] flags);
    sample_class_t c;
    c = '0;
    case (flags)
      FLAG_B_GT: c.b_gt = 1'b1;
      FLAG_EQ:   c.eq   = 1'b1;
      FLAG_A_GT: c.a_gt = 1'b1;
      default:   c.err  = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cmp_result_stats.sv
// Counts comparator outcomes and invalid flag patterns over a window of
// WINDOW valid samples, then publishes the totals with a one-cycle done pulse.
module cmp_result_stats
  import cmp_stats_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             b_gt,
  input  logic             b_a_eq,
  input  logic             a_gt,
  output logic             busy,
  output logic             done,
  output logic             all_onehot,
  output logic [CNT_W-1:0] cnt_b_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_a_gt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned IDX_W = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             win_clr;
  logic             sample;
  sample_class_t    cls;

  logic [CNT_W-1:0] w_b_gt, w_eq, w_a_gt, w_err;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d = state_q;
    win_clr = 1'b0;
    sample  = 1'b0;
    cls     = classify({b_gt, b_a_eq, a_gt});
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          win_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          sample = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample index runs independently of counter saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (win_clr) begin
      idx_q <= '0;
    end else if (sample) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_b_gt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (sample && cls.b_gt),
    .q     (w_b_gt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_eq (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (sample && cls.eq),
    .q     (w_eq)
  );

  sat_counter #(.W(CNT_W)) u_cnt_a_gt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (sample && cls.a_gt),
    .q     (w_a_gt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (win_clr),
    .inc   (sample && cls.err),
    .q     (w_err)
  );

  // Published results load on the DONE cycle, after the last sample has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      all_onehot <= 1'b0;
      cnt_b_gt   <= '0;
      cnt_eq     <= '0;
      cnt_a_gt   <= '0;
      err_cnt    <= '0;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        all_onehot <= (w_err == '0);
        cnt_b_gt   <= w_b_gt;
        cnt_eq     <= w_eq;
        cnt_a_gt   <= w_a_gt;
        err_cnt    <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_cmp_result_stats.sv
// Scoreboard bench: a window-level reference model queues expected results,
// a monitor checks every done pulse and the hold behaviour in between.
module tb_cmp_result_stats;

  logic       clk;
  logic       rst_n;
  logic       st [2];
  logic       v  [2];
  logic [2:0] f  [2];

  logic       bz0, dn0, ao0, bz1, dn1, ao1;
  logic [7:0] cb0, ce0, ca0, cr0;
  logic [2:0] cb1, ce1, ca1, cr1;

  cmp_result_stats dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(v[0]),
    .b_gt(f[0][2]), .b_a_eq(f[0][1]), .a_gt(f[0][0]),
    .busy(bz0), .done(dn0), .all_onehot(ao0),
    .cnt_b_gt(cb0), .cnt_eq(ce0), .cnt_a_gt(ca0), .err_cnt(cr0)
  );

  cmp_result_stats #(.CNT_W(3), .WINDOW(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(v[1]),
    .b_gt(f[1][2]), .b_a_eq(f[1][1]), .a_gt(f[1][0]),
    .busy(bz1), .done(dn1), .all_onehot(ao1),
    .cnt_b_gt(cb1), .cnt_eq(ce1), .cnt_a_gt(ca1), .err_cnt(cr1)
  );

  typedef struct {
    int b; int e; int a; int err; int ao; int due;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t pub [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Window-level model state: 0 idle, 1 collecting, 2 publishing.
  int mst [2];
  int nb [2], ne [2], na [2], nerr [2], ns [2];
  int win  [2] = '{16, 10};
  int maxc [2] = '{255, 7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int x, input int d);
    return (x > maxc[d]) ? maxc[d] : x;
  endfunction

  function automatic bit q_empty(input int d);
    return (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
  endfunction

  function automatic int q_due(input int d);
    return (d == 0) ? exp_q0[0].due : exp_q1[0].due;
  endfunction

  function automatic exp_t q_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: captures inputs at the same edge as the DUT.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mst[d] = 0;
      end else if (mst[d] == 0) begin
        if (st[d]) begin
          mst[d] = 1;
          nb[d] = 0; ne[d] = 0; na[d] = 0; nerr[d] = 0; ns[d] = 0;
        end
      end else if (mst[d] == 1) begin
        if (v[d]) begin
          if ($countones(f[d]) != 1) nerr[d]++;
          else if (f[d][2]) nb[d]++;
          else if (f[d][1]) ne[d]++;
          else na[d]++;
          ns[d]++;
          if (ns[d] == win[d]) begin
            e.b = sat(nb[d], d); e.e = sat(ne[d], d); e.a = sat(na[d], d);
            e.err = sat(nerr[d], d); e.ao = (nerr[d] == 0) ? 1 : 0;
            e.due = cyc + 1;
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            mst[d] = 2;
          end
        end
      end else begin
        mst[d] = 0;
      end
    end
  end

  task automatic mon(input int d, input logic dn, input logic bz, input logic ao,
                     input logic [7:0] cb, input logic [7:0] ce,
                     input logic [7:0] ca, input logic [7:0] cr);
    exp_t e;
    if (!rst_n) begin
      chk($sformatf("reset_vals%0d", d), int'({dn, bz, ao}) + int'(cb) + int'(ce) + int'(ca) + int'(cr), 0);
      pub[d] = '{0, 0, 0, 0, 0, 0};
      return;
    end
    if (!q_empty(d) && cyc > q_due(d)) begin
      chk($sformatf("missing_done%0d", d), cyc, q_due(d));
      e = q_pop(d);
    end
    if (dn) begin
      if (q_empty(d)) begin
        chk($sformatf("unexpected_done%0d", d), 1, 0);
      end else begin
        e = q_pop(d);
        chk($sformatf("done_latency%0d", d), cyc, e.due);
        chk($sformatf("cnt_b_gt%0d", d), int'(cb), e.b);
        chk($sformatf("cnt_eq%0d", d), int'(ce), e.e);
        chk($sformatf("cnt_a_gt%0d", d), int'(ca), e.a);
        chk($sformatf("err_cnt%0d", d), int'(cr), e.err);
        chk($sformatf("all_onehot%0d", d), int'(ao), e.ao);
        pub[d] = e;
      end
    end else begin
      chk($sformatf("hold%0d", d),
          (int'(cb) << 24) | (int'(ce) << 16) | (int'(ca) << 8) | int'(cr) | (int'(ao) << 31),
          (pub[d].b << 24) | (pub[d].e << 16) | (pub[d].a << 8) | pub[d].err | (pub[d].ao << 31));
    end
  endtask

  always @(negedge clk) begin
    mon(0, dn0, bz0, ao0, cb0, ce0, ca0, cr0);
    mon(1, dn1, bz1, ao1, 8'(cb1), 8'(ce1), 8'(ca1), 8'(cr1));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    st[0] = 1'b0; v[0] = 1'b0; st[1] = 1'b0; v[1] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 60; i++) begin
      if ((d == 0) ? dn0 : dn1) return;
      nxt();
    end
    chk($sformatf("done_timeout%0d", d), 0, 1);
  endtask

  function automatic logic [2:0] rnd_flags();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [2:0] pat [4];
    int cnt;
    pat[0] = 3'b100; pat[1] = 3'b010; pat[2] = 3'b001; pat[3] = 3'b100;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin st[d] = 0; v[d] = 0; f[d] = 3'b000; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nxt();
    chk("reset_busy", int'(bz0), 0);

    // Ordered one-hot window.
    st[0] = 1'b1; nxt();
    chk("busy_after_start", int'(bz0), 1);
    for (int i = 0; i < 16; i++) begin v[0] = 1'b1; f[0] = pat[i % 4]; nxt(); end
    chk("no_early_done", int'(dn0), 0);
    wait_done(0);
    chk("t1_b_gt", int'(cb0), 8);
    chk("t1_eq", int'(ce0), 4);
    chk("t1_a_gt", int'(ca0), 4);
    chk("t1_onehot", int'(ao0), 1);
    chk("busy_in_done_pulse", int'(bz0), 0);
    nxt();
    chk("done_one_cycle", int'(dn0), 0);

    // Invalid patterns.
    nxt(); st[0] = 1'b1; nxt();
    for (int i = 0; i < 16; i++) begin
      v[0] = 1'b1;
      f[0] = (i == 2) ? 3'b000 : (i == 7) ? 3'b110 : (i == 12) ? 3'b111 : 3'b010;
      nxt();
    end
    wait_done(0);
    chk("t2_eq", int'(ce0), 13);
    chk("t2_err", int'(cr0), 3);
    chk("t2_onehot", int'(ao0), 0);

    // Saturation on the narrow instance.
    nxt(); st[1] = 1'b1; nxt();
    for (int i = 0; i < 10; i++) begin v[1] = 1'b1; f[1] = 3'b001; nxt(); end
    wait_done(1);
    chk("t3_a_gt_sat", int'(ca1), 7);
    nxt();
    chk("t3_busy_low", int'(bz1), 0);

    // Gaps, start+valid in IDLE, start re-pulsed mid-window.
    nxt(); st[0] = 1'b1; v[0] = 1'b1; f[0] = 3'b100; nxt();
    cnt = 0;
    for (int i = 0; cnt < 16; i++) begin
      v[0] = (i % 2 == 0);
      f[0] = rnd_flags();
      if (i == 9 || i == 14) st[0] = 1'b1;
      if (v[0]) cnt++;
      nxt();
    end
    wait_done(0);

    // Reset mid-window, then a fresh window.
    nxt(); st[0] = 1'b1; nxt();
    for (int i = 0; i < 7; i++) begin v[0] = 1'b1; f[0] = rnd_flags(); nxt(); end
    rst_n = 1'b0;
    nxt(); nxt();
    chk("rst_busy", int'(bz0), 0);
    chk("rst_cnt", int'(cb0) + int'(ce0) + int'(ca0) + int'(cr0) + int'(ao0), 0);
    rst_n = 1'b1;
    nxt(); st[0] = 1'b1; nxt();
    for (int i = 0; i < 16; i++) begin v[0] = 1'b1; f[0] = rnd_flags(); nxt(); end
    wait_done(0);

    // Hold: valid samples with no start leave results untouched.
    nxt(); nxt();
    for (int i = 0; i < 20; i++) begin
      v[0] = 1'b1; f[0] = rnd_flags(); v[1] = 1'b1; f[1] = rnd_flags(); nxt();
    end
    chk("hold_no_busy", int'(bz0), 0);

    // Random traffic on both instances with stray starts.
    for (int r = 0; r < 4; r++) begin
      nxt(); st[0] = 1'b1; st[1] = 1'b1; nxt();
      for (int i = 0; i < 60; i++) begin
        for (int d = 0; d < 2; d++) begin
          v[d] = ($urandom_range(0, 3) != 0);
          f[d] = rnd_flags();
          st[d] = ($urandom_range(0, 7) == 0);
        end
        nxt();
      end
    end

    repeat (30) nxt();
    chk("pending_q0", exp_q0.size(), 0);
    chk("pending_q1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
